// File: rtl/id_stage_pipe.sv
// Decode stage: regfile, EX/MEM/WB operand bypass, load-use bubble
// and a valid/ready ID/EX register with flush and a stall counter.
//
// Ports:
//   i_clk, i_nrst        clock, async active-low reset
//   i_valid/o_ready      IF/ID handshake (instruction in)
//   i_instr, i_pc4       instruction word and its PC+4
//   i_ctrl               pre-decoded control word (pass-through)
//   i_use_rs/i_use_rt    source usage flags
//   i_dst_rd             1: dst=rd, 0: dst=rt
//   i_imm_sign           1: sign-extend imm, 0: zero-extend
//   i_flush              kill the instruction held in ID
//   i_ex_*/i_mem_*       bypass sources from EX and MEM
//   i_wb_*               regfile write port (also bypassed)
//   o_valid/i_ready      ID/EX handshake (instruction out)
//   o_rs/rt_data, o_dst_addr, o_imm, o_pc4, o_ctrl  ID/EX payload
//   o_jr_data            combinational resolved rs for jr
//   o_stall_cnt          saturating load-use stall count
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CTRL_W = 16,
  parameter int SCNT_W = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc4,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_use_rs,
  input  logic              i_use_rt,
  input  logic              i_dst_rd,
  input  logic              i_imm_sign,
  input  logic              i_flush,
  input  logic              i_ex_wen,
  input  logic              i_ex_memrd,
  input  logic [AW-1:0]     i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_wen,
  input  logic [AW-1:0]     i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [AW-1:0]     o_dst_addr,
  output logic [DATA_W-1:0] o_imm,
  output logic [DATA_W-1:0] o_pc4,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_jr_data,
  output logic [SCNT_W-1:0] o_stall_cnt
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [AW-1:0]     rs, rt, rd, dst;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              ex_fwd;
  logic              hazard, adv, load;
  logic              instr_unused;

  logic              valid_q;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q, pc4_q;
  logic [AW-1:0]     dst_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [SCNT_W-1:0] scnt_q, scnt_d;

  assign rs    = i_instr[21 +: AW];
  assign rt    = i_instr[16 +: AW];
  assign rd    = i_instr[11 +: AW];
  assign imm16 = i_instr[15:0];
  assign instr_unused = ^i_instr[31:26];

  assign dst     = i_dst_rd ? rd : rt;
  assign imm_ext = {{(DATA_W-16){imm16[15] & i_imm_sign}}, imm16};

  // A load in EX has no data yet; it is never a bypass source.
  assign ex_fwd = i_ex_wen & ~i_ex_memrd;

  // WB bypass gives write-through on a same-cycle write.
  always_comb begin
    rs_val = rf_q[rs];
    if (rs == '0)
      rs_val = '0;
    else if (ex_fwd && i_ex_addr == rs)
      rs_val = i_ex_data;
    else if (i_mem_wen && i_mem_addr == rs)
      rs_val = i_mem_data;
    else if (i_wb_en && i_wb_addr == rs)
      rs_val = i_wb_data;
  end

  always_comb begin
    rt_val = rf_q[rt];
    if (rt == '0)
      rt_val = '0;
    else if (ex_fwd && i_ex_addr == rt)
      rt_val = i_ex_data;
    else if (i_mem_wen && i_mem_addr == rt)
      rt_val = i_mem_data;
    else if (i_wb_en && i_wb_addr == rt)
      rt_val = i_wb_data;
  end

  assign hazard = i_ex_wen & i_ex_memrd & (i_ex_addr != '0) &
                  ((i_use_rs & (rs == i_ex_addr)) |
                   (i_use_rt & (rt == i_ex_addr)));
  assign adv     = ~valid_q | i_ready;
  assign o_ready = adv & (~hazard | i_flush);
  assign load    = i_valid & o_ready & ~i_flush;

  always_comb begin
    scnt_d = scnt_q;
    if (i_valid && hazard && !i_flush && adv && scnt_q != '1)
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (i_wb_en && i_wb_addr != '0) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      ctrl_q  <= '0;
      scnt_q  <= '0;
    end else begin
      scnt_q <= scnt_d;
      if (adv) begin
        valid_q <= load;
        if (load) begin
          rs_q   <= rs_val;
          rt_q   <= rt_val;
          dst_q  <= dst;
          imm_q  <= imm_ext;
          pc4_q  <= i_pc4;
          ctrl_q <= i_ctrl;
        end
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_rs_data   = rs_q;
  assign o_rt_data   = rt_q;
  assign o_dst_addr  = dst_q;
  assign o_imm       = imm_q;
  assign o_pc4       = pc4_q;
  assign o_ctrl      = ctrl_q;
  assign o_jr_data   = rs_val;
  assign o_stall_cnt = scnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: bypass, load-use bubble,
// back-pressure, flush, immediate extension, write-through, reset.
module tb_id_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int SW = 16;

  logic          i_clk = 1'b0;
  logic          i_nrst;
  logic          i_valid, o_ready;
  logic [31:0]   i_instr;
  logic [DW-1:0] i_pc4;
  logic [CW-1:0] i_ctrl;
  logic          i_use_rs, i_use_rt, i_dst_rd, i_imm_sign, i_flush;
  logic          i_ex_wen, i_ex_memrd;
  logic [AW-1:0] i_ex_addr;
  logic [DW-1:0] i_ex_data;
  logic          i_mem_wen;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic          i_wb_en;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic          o_valid, i_ready;
  logic [DW-1:0] o_rs_data, o_rt_data, o_imm, o_pc4, o_jr_data;
  logic [AW-1:0] o_dst_addr;
  logic [CW-1:0] o_ctrl;
  logic [SW-1:0] o_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  id_stage_pipe dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc4(i_pc4), .i_ctrl(i_ctrl),
    .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_dst_rd(i_dst_rd), .i_imm_sign(i_imm_sign),
    .i_flush(i_flush),
    .i_ex_wen(i_ex_wen), .i_ex_memrd(i_ex_memrd),
    .i_ex_addr(i_ex_addr), .i_ex_data(i_ex_data),
    .i_mem_wen(i_mem_wen), .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_dst_addr(o_dst_addr), .o_imm(o_imm),
    .o_pc4(o_pc4), .o_ctrl(o_ctrl),
    .o_jr_data(o_jr_data), .o_stall_cnt(o_stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet();
    i_valid = 0; i_use_rs = 0; i_use_rt = 0; i_flush = 0;
    i_ex_wen = 0; i_ex_memrd = 0; i_ex_addr = '0; i_ex_data = '0;
    i_mem_wen = 0; i_mem_addr = '0; i_mem_data = '0;
    i_wb_en = 0; i_wb_addr = '0; i_wb_data = '0;
  endtask

  initial begin
    i_nrst = 0; i_ready = 1; i_instr = '0; i_pc4 = '0;
    i_ctrl = '0; i_dst_rd = 0; i_imm_sign = 0;
    quiet();
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_scnt", o_stall_cnt, 0);
    chk("rst_rs", o_rs_data, 0);
    i_nrst = 1;
    step();

    // RF write then read
    i_wb_en = 1; i_wb_addr = 5; i_wb_data = 32'h1234;
    step();
    quiet();
    i_valid = 1; i_use_rs = 1; i_instr = mk(5, 0, 16'h0);
    i_pc4 = 32'h104; i_ctrl = 16'hA5A5;
    step();
    chk("rf_rs", o_rs_data, 32'h1234);
    chk("rf_valid", o_valid, 1);
    chk("rf_pc4", o_pc4, 32'h104);
    chk("rf_ctrl", o_ctrl, 16'hA5A5);

    // EX beats MEM
    i_ex_wen = 1; i_ex_addr = 3; i_ex_data = 32'hAA;
    i_mem_wen = 1; i_mem_addr = 3; i_mem_data = 32'hBB;
    i_instr = mk(3, 0, 16'h0);
    #1;
    chk("jr_ex", o_jr_data, 32'hAA);
    step();
    chk("fwd_ex", o_rs_data, 32'hAA);

    // load-use bubble
    quiet();
    i_ex_wen = 1; i_ex_memrd = 1; i_ex_addr = 7;
    i_valid = 1; i_use_rt = 1; i_dst_rd = 0;
    i_instr = mk(0, 7, 16'h0);
    #1;
    chk("lu_ready", o_ready, 0);
    step();
    chk("lu_bubble", o_valid, 0);
    chk("lu_scnt", o_stall_cnt, 1);
    i_ex_wen = 0; i_ex_memrd = 0; i_ex_addr = '0;
    i_mem_wen = 1; i_mem_addr = 7; i_mem_data = 32'h55;
    #1;
    chk("lu_ready2", o_ready, 1);
    step();
    chk("lu_mem_rt", o_rt_data, 32'h55);
    chk("lu_valid", o_valid, 1);
    chk("lu_dst", o_dst_addr, 7);
    chk("lu_scnt2", o_stall_cnt, 1);

    // back-pressure
    quiet();
    i_ready = 0;
    i_valid = 1; i_use_rs = 1; i_instr = mk(5, 0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", o_ready, 0);
      step();
      chk("bp_valid", o_valid, 1);
      chk("bp_rt", o_rt_data, 32'h55);
    end
    i_ready = 1;
    #1;
    chk("bp_ready1", o_ready, 1);
    step();
    chk("bp_load", o_rs_data, 32'h1234);
    chk("bp_valid2", o_valid, 1);

    // flush under hazard
    quiet();
    i_ex_wen = 1; i_ex_memrd = 1; i_ex_addr = 9;
    i_valid = 1; i_use_rs = 1; i_flush = 1;
    i_instr = mk(9, 0, 16'h0);
    #1;
    chk("fl_ready", o_ready, 1);
    step();
    chk("fl_valid", o_valid, 0);
    chk("fl_scnt", o_stall_cnt, 1);
    chk("fl_hold", o_rs_data, 32'h1234);

    // r0 never forwarded
    quiet();
    i_ex_wen = 1; i_ex_addr = 0; i_ex_data = 32'hFF;
    i_valid = 1; i_use_rs = 1; i_instr = mk(0, 0, 16'h0);
    step();
    chk("r0_rs", o_rs_data, 0);
    chk("r0_valid", o_valid, 1);

    // immediate and rd destination
    quiet();
    i_valid = 1; i_dst_rd = 1; i_imm_sign = 1;
    i_instr = mk(0, 4, 16'h8000);
    step();
    chk("imm_sx", o_imm, 32'hFFFF8000);
    chk("dst_rd", o_dst_addr, 16);
    i_imm_sign = 0;
    step();
    chk("imm_zx", o_imm, 32'h00008000);
    i_dst_rd = 0;

    // write-through, then plain RF read
    quiet();
    i_wb_en = 1; i_wb_addr = 10; i_wb_data = 32'hCAFE;
    i_valid = 1; i_use_rs = 1; i_instr = mk(10, 0, 16'h0);
    step();
    chk("wt_rs", o_rs_data, 32'hCAFE);
    i_wb_en = 0;
    i_instr = mk(0, 10, 16'h0);
    step();
    chk("rf_rt", o_rt_data, 32'hCAFE);

    // async reset mid-transfer
    #3;
    i_nrst = 0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_rt", o_rt_data, 0);
    #2;
    i_nrst = 1;
    quiet();
    i_valid = 1; i_use_rs = 1; i_instr = mk(10, 0, 16'h0);
    step();
    chk("ar_rf", o_rs_data, 0);
    chk("ar_valid2", o_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
